// File: rtl/hart_ctrl.sv
// hart_ctrl: run-control sequencer for the single-hart RV64I core.
//
// Gates the PC write enable, turns the CPU exception vector into
// RUN/HALT/ERROR transitions, accepts debug commands over a valid/ready
// handshake and counts retired instructions.
//
// Ports:
//   clk_i        : clock, all state on the rising edge
//   rst_i        : synchronous active-high reset
//   exceptions_i : [2:0] errors, [3] ECALL, [4] EBREAK, [7:5] ignored for
//                  transitions but latched into cause_o
//   cmd_valid_i  : debug command offered
//   cmd_i        : 0 HALT, 1 RESUME, 2 STEP, 3 CLEAR
//   cmd_ready_o  : command can be accepted (RUN, HALT, ERROR)
//   pc_we_o      : commit of the current instruction
//   state_o      : 0 RST, 1 RUN, 2 HALT, 3 ERROR, 4 STEP
//   cause_o      : latched stop cause
//   instret_o    : retired-instruction counter (wraps)
//
// Build option: define HART_CTRL_STEP_EN to enable single-step. Without it,
// STEP commands are accepted and dropped and the STEP state is unreachable.
//
// state | meaning
// ------+---------------------------------------------------------------
// RST   | hold counter running down after reset or CLEAR
// RUN   | free-running, every clean instruction commits
// HALT  | stopped by trap or HALT command, waiting for RESUME/STEP
// ERROR | stopped by an error exception, only CLEAR leaves
// STEP  | one-cycle single-step, then back to HALT

module hart_ctrl #(
  parameter int CNT_WIDTH  = 32,
  parameter int RESET_HOLD = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           exceptions_i,
  input  logic                 cmd_valid_i,
  input  logic [1:0]           cmd_i,
  output logic                 cmd_ready_o,
  output logic                 pc_we_o,
  output logic [2:0]           state_o,
  output logic [7:0]           cause_o,
  output logic [CNT_WIDTH-1:0] instret_o
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD - 1);

  localparam logic [1:0] CMD_HALT   = 2'd0;
  localparam logic [1:0] CMD_RESUME = 2'd1;
  localparam logic [1:0] CMD_STEP   = 2'd2;
  localparam logic [1:0] CMD_CLEAR  = 2'd3;

  localparam logic [7:0] CAUSE_HALT_CMD = 8'h80;
  localparam logic [7:0] CAUSE_STEP     = 8'h40;

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_RUN   = 3'd1,
    S_HALT  = 3'd2,
    S_ERROR = 3'd3,
    S_STEP  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [7:0]          cause_q, cause_d;
  logic [CNT_WIDTH-1:0] instret_q;

  logic exc_err, exc_trap, accept;

  assign exc_err  = |exceptions_i[2:0];
  assign exc_trap = |exceptions_i[4:3];

  assign cmd_ready_o = (state_q == S_RUN) || (state_q == S_HALT) || (state_q == S_ERROR);
  assign accept      = cmd_valid_i && cmd_ready_o;

  // A faulting or trapping instruction never commits, so the PC stays on it.
  assign pc_we_o = ((state_q == S_RUN) || (state_q == S_STEP)) && (exceptions_i[4:0] == 5'd0);

  assign state_o   = state_q;
  assign cause_o   = cause_q;
  assign instret_o = instret_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cause_d = cause_q;
    case (state_q)
      S_RST: begin
        if (hold_q == '0) state_d = S_RUN;
        else              hold_d  = hold_q - HOLD_W'(1);
      end
      S_RUN, S_STEP: begin
        // Exceptions outrank a same-cycle HALT command; the command is
        // still accepted and simply dropped.
        if (exc_err) begin
          state_d = S_ERROR;
          cause_d = exceptions_i;
        end else if (exc_trap) begin
          state_d = S_HALT;
          cause_d = exceptions_i;
        end else if (state_q == S_STEP) begin
          state_d = S_HALT;
          cause_d = CAUSE_STEP;
        end else if (accept && (cmd_i == CMD_HALT)) begin
          state_d = S_HALT;
          cause_d = CAUSE_HALT_CMD;
        end
      end
      S_HALT: begin
        if (accept && (cmd_i == CMD_RESUME)) begin
          state_d = S_RUN;
          cause_d = 8'h00;
        end
`ifdef HART_CTRL_STEP_EN
        else if (accept && (cmd_i == CMD_STEP)) begin
          state_d = S_STEP;
        end
`endif
      end
      S_ERROR: begin
        if (accept && (cmd_i == CMD_CLEAR)) begin
          state_d = S_RST;
          hold_d  = HOLD_INIT;
          cause_d = 8'h00;
        end
      end
      default: begin
        state_d = S_RST;
        hold_d  = HOLD_INIT;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_RST;
      hold_q    <= HOLD_INIT;
      cause_q   <= 8'h00;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cause_q <= cause_d;
      if (pc_we_o) instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hart_ctrl.sv
// Self-checking bench for hart_ctrl: directed scenarios with fixed expected
// values, then randomized traffic compared against a behavioural model.
// Build option HART_CTRL_STEP_EN selects the expected single-step behaviour.

module tb_hart_ctrl;

  localparam int CW   = 4;
  localparam int HOLD = 2;

  logic          clk;
  logic          rst;
  logic [7:0]    exceptions;
  logic          cmd_valid;
  logic [1:0]    cmd;
  logic          cmd_ready;
  logic          pc_we;
  logic [2:0]    state;
  logic [7:0]    cause;
  logic [CW-1:0] instret;

  hart_ctrl #(.CNT_WIDTH(CW), .RESET_HOLD(HOLD)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .exceptions_i (exceptions),
    .cmd_valid_i  (cmd_valid),
    .cmd_i        (cmd),
    .cmd_ready_o  (cmd_ready),
    .pc_we_o      (pc_we),
    .state_o      (state),
    .cause_o      (cause),
    .instret_o    (instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef HART_CTRL_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: states as plain integers 0..4, reset wait as the
  // number of cycles still to spend in RST.
  int            m_state = 0;
  int            m_wait  = HOLD - 1;
  logic [7:0]    m_cause = 8'h00;
  logic [CW-1:0] m_cnt   = '0;

  logic obs_we, obs_rdy, exp_we, exp_rdy;

  task automatic model_step(input logic r, input logic [7:0] e, input logic v, input logic [1:0] c);
    bit running, acc;
    if (r) begin
      m_state = 0; m_wait = HOLD - 1; m_cause = 8'h00; m_cnt = '0;
      return;
    end
    running = (m_state == 1) || (m_state == 4);
    acc     = v && (m_state >= 1) && (m_state <= 3);
    if (running && e[4:0] == 5'd0) m_cnt = m_cnt + 1'b1;
    if (m_state == 0) begin
      if (m_wait == 0) m_state = 1;
      else m_wait = m_wait - 1;
    end else if (running) begin
      if (e[2:0] != 0)                    begin m_state = 3; m_cause = e; end
      else if (e[4:3] != 0)               begin m_state = 2; m_cause = e; end
      else if (m_state == 4)              begin m_state = 2; m_cause = 8'h40; end
      else if (acc && c == 2'd0)          begin m_state = 2; m_cause = 8'h80; end
    end else if (m_state == 2) begin
      if (acc && c == 2'd1)               begin m_state = 1; m_cause = 8'h00; end
      else if (acc && c == 2'd2 && STEP_EN) m_state = 4;
    end else if (m_state == 3) begin
      if (acc && c == 2'd3) begin m_state = 0; m_wait = HOLD - 1; m_cause = 8'h00; end
    end
  endtask

  // One clock: drive inputs, capture combinational outputs before the edge,
  // advance the model on the edge, return 1 time unit after it.
  task automatic cycle(input logic r, input logic [7:0] e, input logic v, input logic [1:0] c);
    rst = r; exceptions = e; cmd_valid = v; cmd = c;
    #1;
    obs_we  = pc_we;
    obs_rdy = cmd_ready;
    exp_we  = ((m_state == 1) || (m_state == 4)) && (e[4:0] == 5'd0);
    exp_rdy = (m_state >= 1) && (m_state <= 3);
    @(posedge clk);
    model_step(r, e, v, c);
    #1;
  endtask

  task automatic test_reset;
    cycle(1, 8'h00, 0, 0);
    cycle(1, 8'h00, 0, 0);
    checks++; if (state !== 3'd0)  begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (cause !== 8'h00) begin errors++; $display("FAIL reset_cause got %h exp 00", cause); end
    checks++; if (instret !== '0)  begin errors++; $display("FAIL reset_instret got %0d exp 0", instret); end
    checks++; if (pc_we !== 1'b0)  begin errors++; $display("FAIL reset_pc_we got %b exp 0", pc_we); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", cmd_ready); end
    cycle(0, 8'h00, 0, 0);
    checks++; if (obs_we !== 1'b0) begin errors++; $display("FAIL hold1_pc_we got %b exp 0", obs_we); end
    checks++; if (state !== 3'd0)  begin errors++; $display("FAIL hold1_state got %0d exp 0", state); end
    cycle(0, 8'h00, 0, 0);
    checks++; if (state !== 3'd1)  begin errors++; $display("FAIL hold2_state got %0d exp 1", state); end
    for (int i = 0; i < 5; i++) begin
      cycle(0, 8'h00, 0, 0);
      checks++; if (obs_we !== 1'b1) begin errors++; $display("FAIL run_pc_we cycle %0d got %b exp 1", i, obs_we); end
    end
    checks++; if (instret !== 4'd5) begin errors++; $display("FAIL run_instret got %0d exp 5", instret); end
  endtask

  task automatic test_ebreak;
    cycle(0, 8'h10, 0, 0);
    checks++; if (obs_we !== 1'b0)  begin errors++; $display("FAIL ebreak_pc_we got %b exp 0", obs_we); end
    checks++; if (state !== 3'd2)   begin errors++; $display("FAIL ebreak_state got %0d exp 2", state); end
    checks++; if (cause !== 8'h10)  begin errors++; $display("FAIL ebreak_cause got %h exp 10", cause); end
    checks++; if (instret !== 4'd5) begin errors++; $display("FAIL ebreak_instret got %0d exp 5", instret); end
    cycle(0, 8'h00, 1, 1);
    checks++; if (state !== 3'd1)   begin errors++; $display("FAIL resume_state got %0d exp 1", state); end
    checks++; if (cause !== 8'h00)  begin errors++; $display("FAIL resume_cause got %h exp 00", cause); end
  endtask

  task automatic test_error_clear;
    cycle(0, 8'h02, 1, 0);
    checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL err_ready got %b exp 1", obs_rdy); end
    checks++; if (obs_we !== 1'b0)  begin errors++; $display("FAIL err_pc_we got %b exp 0", obs_we); end
    checks++; if (state !== 3'd3)   begin errors++; $display("FAIL err_state got %0d exp 3", state); end
    checks++; if (cause !== 8'h02)  begin errors++; $display("FAIL err_cause got %h exp 02", cause); end
    cycle(0, 8'h08, 1, 1);
    checks++; if (state !== 3'd3)   begin errors++; $display("FAIL err_ignore_state got %0d exp 3", state); end
    checks++; if (cause !== 8'h02)  begin errors++; $display("FAIL err_ignore_cause got %h exp 02", cause); end
    cycle(0, 8'h00, 1, 3);
    checks++; if (state !== 3'd0)   begin errors++; $display("FAIL clear_state got %0d exp 0", state); end
    checks++; if (cause !== 8'h00)  begin errors++; $display("FAIL clear_cause got %h exp 00", cause); end
    cycle(0, 8'h00, 0, 0);
    checks++; if (state !== 3'd0)   begin errors++; $display("FAIL clear_hold_state got %0d exp 0", state); end
    cycle(0, 8'h00, 0, 0);
    checks++; if (state !== 3'd1)   begin errors++; $display("FAIL clear_run_state got %0d exp 1", state); end
    checks++; if (instret !== 4'd5) begin errors++; $display("FAIL clear_instret got %0d exp 5", instret); end
  endtask

  task automatic test_step;
    cycle(0, 8'h00, 1, 0);
    checks++; if (state !== 3'd2)   begin errors++; $display("FAIL halt_state got %0d exp 2", state); end
    checks++; if (cause !== 8'h80)  begin errors++; $display("FAIL halt_cause got %h exp 80", cause); end
    checks++; if (instret !== 4'd6) begin errors++; $display("FAIL halt_instret got %0d exp 6", instret); end
    for (int s = 0; s < 2; s++) begin
      cycle(0, 8'h00, 1, 2);
      checks++; if (obs_we !== 1'b0) begin errors++; $display("FAIL step%0d_cmd_pc_we got %b exp 0", s, obs_we); end
      checks++; if (state !== (STEP_EN ? 3'd4 : 3'd2)) begin errors++; $display("FAIL step%0d_state got %0d exp %0d", s, state, STEP_EN ? 4 : 2); end
      cycle(0, 8'h00, 0, 0);
      checks++; if (obs_we !== STEP_EN) begin errors++; $display("FAIL step%0d_pc_we got %b exp %b", s, obs_we, STEP_EN); end
      checks++; if (state !== 3'd2) begin errors++; $display("FAIL step%0d_after_state got %0d exp 2", s, state); end
      checks++; if (cause !== (STEP_EN ? 8'h40 : 8'h80)) begin errors++; $display("FAIL step%0d_cause got %h exp %h", s, cause, STEP_EN ? 8'h40 : 8'h80); end
    end
    checks++; if (instret !== (STEP_EN ? 4'd8 : 4'd6)) begin errors++; $display("FAIL step_instret got %0d exp %0d", instret, STEP_EN ? 8 : 6); end
    cycle(0, 8'h00, 1, 1);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL step_resume_state got %0d exp 1", state); end
  endtask

  task automatic test_rst_mid;
    cycle(0, 8'h00, 1, 0);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL mid_halt_state got %0d exp 2", state); end
    cycle(1, 8'h00, 0, 0);
    checks++; if (state !== 3'd0)   begin errors++; $display("FAIL mid_rst_state got %0d exp 0", state); end
    checks++; if (cause !== 8'h00)  begin errors++; $display("FAIL mid_rst_cause got %h exp 00", cause); end
    checks++; if (instret !== '0)   begin errors++; $display("FAIL mid_rst_instret got %0d exp 0", instret); end
    checks++; if (pc_we !== 1'b0)   begin errors++; $display("FAIL mid_rst_pc_we got %b exp 0", pc_we); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", cmd_ready); end
  endtask

  task automatic test_wrap;
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 0);
    for (int i = 0; i < 17; i++) cycle(0, 8'h00, 0, 0);
    checks++; if (instret !== 4'd1) begin errors++; $display("FAIL wrap_instret got %0d exp 1", instret); end
  endtask

  task automatic test_random;
    logic [7:0] e;
    logic       r;
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 79) == 0);
      e = ($urandom_range(0, 5) == 0) ? 8'($urandom) : {3'($urandom), 5'd0};
      cycle(r, e, 1'($urandom), 2'($urandom));
      checks++; if (obs_we !== exp_we)   begin errors++; $display("FAIL rnd_pc_we i=%0d got %b exp %b", i, obs_we, exp_we); end
      checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL rnd_ready i=%0d got %b exp %b", i, obs_rdy, exp_rdy); end
      checks++; if (state !== 3'(m_state)) begin errors++; $display("FAIL rnd_state i=%0d got %0d exp %0d", i, state, m_state); end
      checks++; if (cause !== m_cause)   begin errors++; $display("FAIL rnd_cause i=%0d got %h exp %h", i, cause, m_cause); end
      checks++; if (instret !== m_cnt)   begin errors++; $display("FAIL rnd_instret i=%0d got %0d exp %0d", i, instret, m_cnt); end
    end
  endtask

  initial begin
    rst = 1'b1; exceptions = 8'h00; cmd_valid = 1'b0; cmd = 2'd0;
    test_reset;
    test_ebreak;
    test_error_clear;
    test_step;
    test_rst_mid;
    test_wrap;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hart_ctrl.md
# hart_ctrl

Run-control sequencer for the single-hart RV64I core. Owns the PC write enable, turns the CPU exception vector into RUN/HALT/ERROR transitions, and accepts debug commands (halt, resume, single-step, clear) through a valid/ready handshake. Sits between the top level, the PC register and the CPU. It also keeps a retired-instruction counter for the display and debug logic.

## Interface
- `CNT_WIDTH`, 32, width of the retired-instruction counter.
- `RESET_HOLD`, 2, cycles spent in RST after `rst_i` deasserts before entering RUN (≥1).
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `exceptions_i` in 8: CPU exception vector for the current instruction.
  - Bits [2:0] are errors; bit 3 is ECALL; bit 4 is EBREAK; bits [7:5] are ignored.
- `cmd_valid_i` in 1: a debug command is offered.
- `cmd_i` in 2: command code: 0 HALT, 1 RESUME, 2 STEP, 3 CLEAR.
- `cmd_ready_o` out 1: the block can accept a command this cycle.
- `pc_we_o` out 1: PC write enable (commit of the current instruction).
- `state_o` out 3: current state: 0 RST, 1 RUN, 2 HALT, 3 ERROR, 4 STEP.
- `cause_o` out 8: latched stop cause.
- `instret_o` out CNT_WIDTH: count of committed instructions.

## Operation
- **Commit gating.**
  - `pc_we_o` = (state RUN or STEP) && `exceptions_i[4:0]`==0.
  - A faulting or trapping instruction never commits, so the PC stays on it.
- **Handshake.**
  - `cmd_ready_o` = 1 in RUN, HALT and ERROR; it is 0 in RST and STEP.
  - A command is accepted when `cmd_valid_i && cmd_ready_o`.
  - A command that is not legal in the current state is still accepted, and it is dropped with no effect.
- **RST.**
  - A hold counter loads RESET_HOLD-1 while `rst_i` is high, then counts down.
  - At zero the block goes to RUN.
- **RUN.** Transitions, in priority order:
  1. Any of `exceptions_i[2:0]` set → ERROR; `cause_o` = `exceptions_i`.
  2. Otherwise bit 3 or bit 4 set → HALT; `cause_o` = `exceptions_i`.
  3. Otherwise an accepted HALT → HALT; `cause_o` = 8'h80.
- **HALT.**
  - Accepted RESUME → RUN; `cause_o` is cleared.
  - Accepted STEP → STEP.
  - HALT and CLEAR are ignored.
- **STEP.** Lasts exactly one cycle.
  - Exception rules match RUN (ERROR or HALT, with `cause_o` = `exceptions_i`).
  - Otherwise the instruction commits and the block goes to HALT with `cause_o` = 8'h40.
- **ERROR.**
  - Only an accepted CLEAR has an effect: → RST, hold counter reloaded, `cause_o` cleared.
  - The PC itself is not reset by this block.
- **Exceptions outside RUN/STEP.** `exceptions_i` is ignored in HALT, ERROR and RST.
- **Counter.** `instret_o` increments by 1 on every cycle with `pc_we_o`=1 and wraps modulo 2^CNT_WIDTH. CLEAR does not reset it; only `rst_i` does.
- **Simultaneous exception and command.** An exception in RUN takes priority over a HALT command in the same cycle. The command is still accepted and dropped.

## Timing
- Reset values:
  - `state_o` = 0 (RST), `pc_we_o` = 0, `cmd_ready_o` = 0.
  - `cause_o` = 0, `instret_o` = 0.
- Latencies:
  - `pc_we_o` and `cmd_ready_o` are combinational from the registered state; `pc_we_o` also depends on `exceptions_i`.
  - `state_o`, `cause_o` and `instret_o` update on the edge after the triggering cycle.
- First commit:
  - With `rst_i` deasserted at edge N, the state becomes RUN at edge N+RESET_HOLD.
  - The first `pc_we_o` pulse is in the cycle that follows that edge.
- `rst_i` mid-operation: the block returns to RST at the next edge with all reset values, from any state.
- STEP gives exactly one `pc_we_o` pulse at most, then HALT on the next edge.

## Configuration
- `HART_CTRL_STEP_EN`
  - Defined: single-step works as described.
  - Undefined:
    - STEP commands are accepted and dropped; the STEP state is unreachable.
    - Cause code 8'h40 never appears.
    - `state_o` never shows 4.

## Test plan
- Reset release with RESET_HOLD=2 and no exceptions → state 0, 0, then 1; `pc_we_o` high from the third cycle; `instret_o` = 5 after 5 RUN cycles.
- In RUN, `exceptions_i`=8'h10 (EBREAK) → `pc_we_o`=0 that cycle; next cycle `state_o`=2, `cause_o`=8'h10, `instret_o` unchanged.
- In RUN, `exceptions_i`=8'h02 together with a HALT command → `cmd_ready_o`=1, state becomes 3 (ERROR), `cause_o`=8'h02. A following CLEAR → state 0, `cause_o`=0, then RUN after 2 cycles.
- HALT command in RUN, then STEP twice (with `HART_CTRL_STEP_EN`) → each STEP gives one `pc_we_o` pulse, `state_o` goes 4 then 2, `cause_o`=8'h40, `instret_o` advances by exactly 2.
- Same STEP sequence without `HART_CTRL_STEP_EN` → no `pc_we_o` pulse; state stays 2.
- CNT_WIDTH=4 with 17 clean RUN cycles → `instret_o` wraps to 1. `rst_i` asserted while in HALT → all outputs return to reset values at the next edge.
